// File: rtl/modexp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : modexp_pkg
//  Description : Shared types and helpers for the modular exponentiator:
//                FSM state encoding, modmul latency constant and an
//                end-to-end latency function (start-accept edge to done edge).
//  Revision    : 1.0 - initial release
// ============================================================================
package modexp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_SCAN   = 3'd2,
        ST_SQUARE = 3'd3,
        ST_MULT   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam int unsigned c_DEFAULT_WIDTH  = 128;
    // One load cycle plus one cycle per multiplier bit.
    localparam int unsigned c_MODMUL_LATENCY = c_DEFAULT_WIDTH + 1;

    function automatic int unsigned modmul_latency(input int unsigned width);
        return width + 1;
    endfunction

    // Cycles from the edge that accepts start to the edge after which done
    // is high. ones = popcount(exponent), lz = leading zeros of exponent.
    function automatic int unsigned modexp_latency(
        input int unsigned width,
        input int unsigned ones,
        input int unsigned lz,
        input bit          skip,
        input bit          invalid
    );
        if (invalid)
            return 2;
        if (!skip)
            return 2 + (width + ones) * modmul_latency(width);
        if (lz == width)
            return 2 + width;
        return 2 + lz + (width - lz + ones) * modmul_latency(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/modexp_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : modexp_engine_if
//  Description : Request/response bundle of the modular exponentiator.
//                master : start, base, exponent, modulus -> ; <- busy, done,
//                         result, error
//                slave  : the exponentiator side (mirror of master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface modexp_engine_if #(
    parameter int WIDTH = 128
);
    logic             start;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] exponent;
    logic [WIDTH-1:0] modulus;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             error;

    modport master (
        output start, base, exponent, modulus,
        input  busy, done, result, error
    );

    modport slave (
        input  start, base, exponent, modulus,
        output busy, done, result, error
    );
endinterface
`default_nettype wire

// File: rtl/modexp_engine_modmul.sv
`default_nettype none
// ============================================================================
//  Module      : modmul_interleaved
//  Description : Bit-serial interleaved modular multiplier, p = a*b mod n.
//                Requires a < n and b < n. Latency WIDTH+1 cycles: the load
//                cycle plus WIDTH steps scanning a from MSB to LSB.
//  Ports       : clk, reset (sync, active-high)
//                load      - capture a, b, n and start a product
//                a, b, n   - operands and modulus
//                ready     - high in the cycle p is valid (last step)
//                p         - product; combinational result of the last step
//  Revision    : 1.0 - initial release
// ============================================================================
module modmul_interleaved #(
    parameter int WIDTH = 128
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    input  wire logic [WIDTH-1:0] n,
    output logic                  ready,
    output logic [WIDTH-1:0]      p
);
    localparam int c_K_W = $clog2(WIDTH);
    localparam logic [c_K_W-1:0] c_K_TOP = c_K_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_t;     // running remainder, always < n between steps
    logic [c_K_W-1:0] r_k;
    logic             r_run;

    logic [WIDTH+1:0] w_n_ext;
    logic [WIDTH+1:0] w_t2;
    logic [WIDTH+1:0] w_s1;
    logic [WIDTH-1:0] w_s2;

    // 2T + a_k*b < 3n, so two conditional subtractions bring it below n.
    always_comb begin
        w_n_ext = {2'b00, r_n};
        w_t2    = {1'b0, r_t, 1'b0} + (r_a[WIDTH-1] ? {2'b00, r_b} : '0);
        w_s1    = (w_t2 >= w_n_ext) ? (w_t2 - w_n_ext) : w_t2;
        w_s2    = WIDTH'((w_s1 >= w_n_ext) ? (w_s1 - w_n_ext) : w_s1);
    end

    assign p     = w_s2;
    assign ready = r_run && (r_k == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_n   <= '0;
            r_t   <= '0;
            r_k   <= '0;
            r_run <= 1'b0;
        end else if (load) begin
            r_a   <= a;
            r_b   <= b;
            r_n   <= n;
            r_t   <= '0;
            r_k   <= c_K_TOP;
            r_run <= 1'b1;
        end else if (r_run) begin
            r_t <= w_s2;
            r_a <= {r_a[WIDTH-2:0], 1'b0};
            if (r_k == '0)
                r_run <= 1'b0;
            else
                r_k <= r_k - c_K_W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/modexp_engine.sv
`default_nettype none
// ============================================================================
//  Module      : modexp_engine
//  Description : Sequential modular exponentiator, result = base^exponent mod
//                modulus, left-to-right square-and-multiply on one shared
//                interleaved modular multiplier.
//  Ports       : clk, reset (sync, active-high)
//                bus (slave) - start/base/exponent/modulus in,
//                              busy/done/result/error out
//  Options     : MODEXP_SKIP_LZ_EN - skip leading zero exponent bits in a
//                SCAN state (one cycle each) instead of squaring R=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module modexp_engine
    import modexp_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  wire logic      clk,
    input  wire logic      reset,
    modexp_engine_if.slave bus
);
    localparam int c_IDX_W = $clog2(WIDTH);
    localparam logic [c_IDX_W-1:0] c_IDX_TOP = c_IDX_W'(WIDTH - 1);

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0]   r_base;
    logic [WIDTH-1:0]   r_exp;
    logic [WIDTH-1:0]   r_mod;
    logic [WIDTH-1:0]   r_acc;     // running value R
    logic [c_IDX_W-1:0] r_idx;     // exponent bit index i
    logic               r_err;
    logic               r_mm_go;   // first cycle of a modmul: load operands
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic               r_error;

    logic               w_invalid;
    logic               w_in_mm;
    logic               w_mm_ready;
    logic [WIDTH-1:0]   w_mm_b;
    logic [WIDTH-1:0]   w_mm_p;
    logic               w_busy_d;
    logic               w_done_d;
    logic               w_mm_go_d;
`ifdef MODEXP_SKIP_LZ_EN
    logic [c_IDX_W-1:0] w_idx_m1;
    assign w_idx_m1 = r_idx - c_IDX_W'(1);
`endif

    assign w_invalid = (r_mod < WIDTH'(2)) || (r_base >= r_mod);
    assign w_in_mm   = (r_state == ST_SQUARE) || (r_state == ST_MULT);
    assign w_mm_b    = (r_state == ST_MULT) ? r_base : r_acc;

    modmul_interleaved #(
        .WIDTH (WIDTH)
    ) u_modmul (
        .clk   (clk),
        .reset (reset),
        .load  (r_mm_go),
        .a     (r_acc),
        .b     (w_mm_b),
        .n     (r_mod),
        .ready (w_mm_ready),
        .p     (w_mm_p)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start)
                    w_state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (w_invalid)
                    w_state_next = ST_DONE;
`ifdef MODEXP_SKIP_LZ_EN
                else if (!r_exp[WIDTH-1])
                    w_state_next = ST_SCAN;
`endif
                else
                    w_state_next = ST_SQUARE;
            end
`ifdef MODEXP_SKIP_LZ_EN
            // Bit i is known zero here; look ahead at bit i-1 so that each
            // leading zero costs exactly one cycle.
            ST_SCAN: begin
                if (r_idx == '0)
                    w_state_next = ST_DONE;
                else if (r_exp[w_idx_m1])
                    w_state_next = ST_SQUARE;
            end
`endif
            ST_SQUARE: begin
                if (w_mm_ready) begin
                    if (r_exp[r_idx])
                        w_state_next = ST_MULT;
                    else if (r_idx == '0)
                        w_state_next = ST_DONE;
                end
            end
            ST_MULT: begin
                if (w_mm_ready)
                    w_state_next = (r_idx == '0) ? ST_DONE : ST_SQUARE;
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------- output decode
    // busy/done are registered: busy rises at the accepting edge and falls
    // on the same edge that raises the one-cycle done pulse.
    always_comb begin
        w_busy_d  = (w_state_next != ST_IDLE);
        w_done_d  = (r_state == ST_DONE);
        w_mm_go_d = ((w_state_next == ST_SQUARE) || (w_state_next == ST_MULT))
                    && (!w_in_mm || w_mm_ready);
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_base   <= '0;
            r_exp    <= '0;
            r_mod    <= '0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_err    <= 1'b0;
            r_mm_go  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_error  <= 1'b0;
        end else begin
            r_busy  <= w_busy_d;
            r_done  <= w_done_d;
            r_mm_go <= w_mm_go_d;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_base   <= bus.base;
                        r_exp    <= bus.exponent;
                        r_mod    <= bus.modulus;
                        r_err    <= 1'b0;
                        r_result <= '0;
                        r_error  <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (w_invalid) begin
                        r_err <= 1'b1;
                        r_acc <= '0;
                    end else begin
                        r_acc <= WIDTH'(1);
                        r_idx <= c_IDX_TOP;
                    end
                end
`ifdef MODEXP_SKIP_LZ_EN
                ST_SCAN: begin
                    if (r_idx != '0)
                        r_idx <= w_idx_m1;
                end
`endif
                ST_SQUARE: begin
                    if (w_mm_ready) begin
                        r_acc <= w_mm_p;
                        // A set bit keeps i for the following MULT.
                        if (!r_exp[r_idx] && (r_idx != '0))
                            r_idx <= r_idx - c_IDX_W'(1);
                    end
                end
                ST_MULT: begin
                    if (w_mm_ready) begin
                        r_acc <= w_mm_p;
                        if (r_idx != '0)
                            r_idx <= r_idx - c_IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    r_result <= r_err ? '0 : r_acc;
                    r_error  <= r_err;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.error  = r_error;
endmodule
`default_nettype wire

// File: doc/modexp_engine.md
# modexp_engine

Parametrised sequential modular exponentiator that computes result = base^exponent mod modulus using left-to-right square-and-multiply over a bit-serial interleaved modular multiplier. It is the successor to the fixed-function exponentiation stage inside the RSA `control` path. It generalises operand width, adds a start/busy/done handshake and input validation with an error flag, and has an optional leading-zero skip. Encrypt and decrypt both use this block; they differ only in the exponent supplied (e or d).

## Interface
- `WIDTH`, default 128: width of base, exponent, modulus and result (≥ 4).
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  request; sampled only in IDLE.
- `base`  input  WIDTH  message/ciphertext; captured on accepted start.
- `exponent`  input  WIDTH  e or d; captured on accepted start.
- `modulus`  input  WIDTH  n = p·q; captured on accepted start.
- `busy`  output  1  high from the cycle after start is accepted until done.
- `done`  output  1  single-cycle completion pulse.
- `result`  output  WIDTH  final value; held until next accepted start.
- `error`  output  1  invalid operands; valid with done, held like result.

## Operation
- Reset (synchronous, active-high): all outputs are 0 and the state is IDLE. Reset mid-operation aborts immediately with no done pulse.
- States are IDLE → CHECK → (SCAN) → SQUARE ⇄ MULT → DONE → IDLE.
- **IDLE:** start=1 captures the inputs, clears result and error, and goes to CHECK. start in any other state is ignored.
- **CHECK (1 cycle):** if modulus < 2 or base ≥ modulus, set error=1 and result=0, then go to DONE. Otherwise set R=1 and bit index i=WIDTH−1.
- **SQUARE:** computes R ← R·R mod n. Then, if exponent[i]=1, go to MULT. Otherwise decrement i, or go to DONE if i=0.
- **MULT:** computes R ← R·base mod n. Then decrement i, or go to DONE if i=0.
- **DONE (1 cycle):** done=1, busy=0, result=R (or 0 on error). Then go to IDLE.
- **Modmul (interleaved):** scan multiplier a from MSB down. Each step computes T ← 2T + a_k·b, then subtracts n at most twice so that T < n. T is WIDTH+2 bits wide. Operands are always < n, so no pre-reduction is needed.
- Exponent 0 gives result 1. Base 0 with a non-zero exponent gives result 0.

## Timing
- Each modmul takes WIDTH+1 cycles: 1 load cycle plus WIDTH bit steps.
- Let t0 be the edge where start is sampled in IDLE. done is high after the edge at t0+L, with busy high in the cycles between.
- Without skip: L = 2 + (WIDTH + popcount(exponent))·(WIDTH+1).
- With skip (see Configuration): L = 2 + z + (WIDTH − z + popcount(exponent))·(WIDTH+1), where z is the number of leading zeros. If exponent = 0, L = 2 + WIDTH.
- Error path: L = 2.
- Back-to-back operation: start may be asserted in the cycle right after done and is accepted then.

## Configuration
- `MODEXP_SKIP_LZ_EN` defined: adds a SCAN state between CHECK and SQUARE. SCAN spends 1 cycle per leading zero exponent bit, decrementing i with R=1. It enters SQUARE at the first set bit, or goes to DONE with result 1 if no bit is set.
- `MODEXP_SKIP_LZ_EN` undefined: no SCAN state. All WIDTH bits are squared.
- Result values are identical in both builds; only latency differs.

## Structure
- Package `modexp_pkg` holds:
  - the state enum (IDLE, CHECK, SCAN, SQUARE, MULT, DONE);
  - the localparam for modmul latency (WIDTH+1);
  - a latency function used by the bench.
- Sub-module `modmul_interleaved`, with the same WIDTH parameter:
  - ports clk, reset, load, a, b, n, ready, p;
  - ready pulses on the cycle p is valid;
  - instantiated once and shared between SQUARE and MULT.

## Test plan
- **Small exponentiation:** WIDTH=16, base=4, exponent=13, modulus=497 → result=445, error=0, done exactly L=325 cycles after start (no skip); L=2+12+(4+3)·17=133 with skip.
- **RSA round trip:** WIDTH=16, n=3233. Encrypt m=65 with e=17 → 2790. Then decrypt 2790 with d=2753 → 65.
- **Invalid operands:** modulus=1 → error=1, result=0, done at L=2. base=500 with modulus=497 → error=1, result=0, done at L=2.
- **Edge exponents:** exponent=0, base=7, modulus=11 → result=1. exponent=1, base=0, modulus=11 → result=0.
- **Reset mid-operation:** start a WIDTH=16 run, assert reset at cycle 50 → busy=0, done never pulses, result=0. A fresh start afterwards yields the correct result.
- **Start while busy:** assert start with different operands mid-run → ignored, and the original result completes. A start the cycle after done is accepted.
